// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle RV32I control unit.
//   state_t   - control FSM states
//   OP_*      - supported opcodes
//   ALUOP_*, ALU_*, RES_*, SRCA_*, SRCB_*, IMM_* - datapath select encodings
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_JAL,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational ALU decoder.
//   alu_op_i      - ALUOp from the control FSM (00 add, 01 sub, 10 by funct3)
//   funct3_i      - instruction bits 14:12
//   op5_i         - opcode bit 5 (1 for R-type, 0 for I-type ALU)
//   funct7_5_i    - instruction bit 30
//   alu_control_o - ALU operation select
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7_5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Bit 30 is part of the immediate for addi, so op[5] must gate it.
          3'b000:  alu_control_o = (op5_i & funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle control FSM for an RV32I subset datapath
// (lw, sw, R-type, I-type ALU, beq/bne, jal).
//   clk, rst          - clock, asynchronous active-high reset
//   op, funct3, funct7_5 - instruction fields from the instruction register
//   zero              - ALU zero flag, used for branch decisions
//   mem_ready         - memory completes the current access this cycle
//   mem_req, AdrSrc, MemWrite            - memory port control
//   IRWrite, PCWrite, RegWrite           - architectural state enables
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc - datapath selects
//   illegal           - one-cycle pulse on an unsupported opcode
// Only the state is registered; every output is combinational.
module mc_control
  import mc_pkg::*;
#(
  parameter logic MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic       rdy;
  logic       br_take;
  logic [1:0] alu_op;

  // Without the handshake every memory access completes in one cycle.
  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin
    case (funct3)
      3'b000:  br_take = zero;
      3'b001:  br_take = ~zero;
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_LW, OP_I: ImmSrc = IMM_I;
      OP_SW:       ImmSrc = IMM_S;
      OP_BR:       ImmSrc = IMM_B;
      OP_JAL:      ImmSrc = IMM_J;
      default:     ImmSrc = IMM_I;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7_5_i    (funct7_5),
    .alu_control_o (ALUControl)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    alu_op    = ALUOP_ADD;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 goes straight from the ALU result into the PC.
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = rdy;
        PCWrite   = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute OldPC + imm; ALUOut holds the branch/jal target.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = rdy;
        if (rdy) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        // Jump to the target in ALUOut while the ALU forms OldPC+4 for rd.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        PCWrite = br_take;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized scoreboard bench for mc_control.
// Each instruction is expanded into a list of steps (memory accesses with
// random stall lengths, one-cycle internal steps); every step that must show
// a visible action (a write strobe, illegal, or an ALU operation on a
// register operand) pushes the expected cycle number and output vector.
// A negedge monitor pops and compares whenever the DUT shows such an action.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, AdrSrc, IRWrite, MemWrite, PCWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  mc_control dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  logic [49:0] exp_q[$];
  bit          plan_q[$];
  int          plan_base;
  int          plan_t;

  logic [17:0] outv;
  assign outv = {mem_req, AdrSrc, IRWrite, MemWrite, PCWrite, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};

  function automatic logic [17:0] pk(input logic mr, input logic adr, input logic irw,
                                     input logic mw, input logic pcw, input logic rw,
                                     input logic [1:0] res, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] ctl,
                                     input logic [1:0] imm, input logic ill);
    return {mr, adr, irw, mw, pcw, rw, res, sa, sb, ctl, imm, ill};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == LW || o == IT) return 2'b00;
    if (o == SW) return 2'b01;
    if (o == BR) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] ctl_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (o[5] && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rnd_k();
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  // Memory step: k wait cycles then the completing cycle, which may carry an event.
  task automatic step_mem(input int k, input bit has_ev, input logic [17:0] v);
    for (int i = 0; i < k; i++) begin
      plan_q.push_back(1'b0);
      plan_t++;
    end
    if (has_ev) exp_q.push_back({32'(plan_base + plan_t), v});
    plan_q.push_back(1'b1);
    plan_t++;
  endtask

  // Internal step: one cycle, mem_ready randomized because it must be ignored.
  task automatic step_nop(input bit has_ev, input logic [17:0] v);
    if (has_ev) exp_q.push_back({32'(plan_base + plan_t), v});
    plan_q.push_back(1'($urandom_range(0, 1)));
    plan_t++;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int kfetch, input int kdata);
    logic [1:0] im;
    logic       tk;
    int         kf, kd;
    im = imm_of(o);
    tk = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
    kf = (kfetch >= 0) ? kfetch : rnd_k();
    kd = (kdata >= 0) ? kdata : rnd_k();
    plan_q.delete();
    plan_base = cyc;
    plan_t    = 0;
    step_mem(kf, 1'b1, pk(1, 0, 1, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, im, 0));
    case (o)
      LW: begin
        step_nop(1'b0, '0);
        step_nop(1'b1, pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, im, 0));
        step_mem(kd, 1'b0, '0);
        step_nop(1'b1, pk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, im, 0));
      end
      SW: begin
        step_nop(1'b0, '0);
        step_nop(1'b1, pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, im, 0));
        step_mem(kd, 1'b1, pk(1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 0));
      end
      RT, IT: begin
        step_nop(1'b0, '0);
        step_nop(1'b1, pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, (o == IT) ? 2'b01 : 2'b00,
                          ctl_of(o, f3, f7), im, 0));
        step_nop(1'b1, pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, im, 0));
      end
      BR: begin
        step_nop(1'b0, '0);
        step_nop(1'b1, pk(0, 0, 0, 0, tk, 0, 2'b00, 2'b10, 2'b00, 3'b001, im, 0));
      end
      JL: begin
        step_nop(1'b0, '0);
        step_nop(1'b1, pk(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 3'b000, im, 0));
        step_nop(1'b1, pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, im, 0));
      end
      default: step_nop(1'b1, pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, im, 1));
    endcase
    op = o; funct3 = f3; funct7_5 = f7; zero = z;
    foreach (plan_q[i]) begin
      mem_ready = plan_q[i];
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst &&
        (IRWrite || PCWrite || RegWrite || MemWrite || illegal || ALUSrcA == 2'b10)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL ev_unexpected: got cyc=%0d out=%h expected none", cyc, outv);
      end else begin
        check("ev", {14'd0, 32'(cyc), outv}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] o;
    logic [2:0] f3;
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    check("reset_out", 64'(outv), 64'(pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0)));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    cyc = 0;

    // Directed cases first, then random traffic.
    run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 2);
    run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 0);
    run_instr(BR, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(BR, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(BR, 3'b001, 1'b0, 1'b0, 0, 0);
    run_instr(BR, 3'b100, 1'b0, 1'b1, 0, 0);
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(JL, 3'b000, 1'b0, 1'b0, 1, 0);
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = BR;
        5: o = JL;
        default: o = 7'($urandom_range(0, 127));
      endcase
      f3 = 3'($urandom_range(0, 7));
      if (o == BR && $urandom_range(0, 3) != 0) f3 = {2'b00, 1'($urandom_range(0, 1))};
      run_instr(o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    // Reset while a store waits in MEMWRITE.
    op = SW; funct3 = 3'b010; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    #1;
    check("mw_wait", 64'({mem_req, AdrSrc, MemWrite}), 64'(3'b110));
    rst = 1'b1;
    #1;
    check("rst_in_mw", 64'(outv), 64'(pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm_of(SW), 0)));
    @(posedge clk); #1;
    check("rst_hold_mw", 64'({MemWrite, RegWrite, IRWrite}), 64'd0);
    rst = 1'b0;
    op = RT; mem_ready = 1'b1;
    #1;
    check("post_rst_fetch", 64'({IRWrite, PCWrite, MemWrite}), 64'(3'b110));
    @(posedge clk); #1;
    check("post_rst_decode", 64'(outv), 64'(pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0)));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
